pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer for the RISC-V datapath. Sits directly downstream of the next-PC branch mux: it consumes the selected next PC, holds the architectural PC, and runs a request/response handshake with instruction memory. It presents the fetched instruction with a valid flag to decode, and supports stall, flush/redirect, misalignment fault and a fetch timeout.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 255, max cycles spent in WAIT before fault (8-bit counter).

Ports:
clock  input  1  rising-edge system clock
reset  input  1  asynchronous, active-low reset
pc_next  input  32  next PC from the branch-select mux (PC+4 or branch target)
stall  input  1  hold current instruction; do not advance PC
flush  input  1  redirect: discard current/in-flight fetch and load pc_next
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (equals pc while imem_req=1)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
pc  output  32  current PC
pc_plus4  output  32  pc + 4, feeds the next-PC mux adder input
instr  output  32  fetched instruction, held stable while instr_valid=1
instr_valid  output  1  instr is valid for decode
fault  output  1  sticky: misaligned PC or fetch timeout
fault_code  output  2  00 none, 01 misaligned, 10 timeout

Behaviour:
- Reset (reset=0, async): pc=RESET_VECTOR, state=IDLE, imem_req=0, instr=0, instr_valid=0, fault=0, fault_code=00, drop flag=0, timeout counter=0.
- pc_plus4 is combinational: pc+4 mod 2^32 (0xFFFF_FFFC -> 0x0000_0000). imem_addr=pc always.
- IDLE: one cycle after reset release, then REQ. If RESET_VECTOR[1:0]!=0, go to FAULT with code 01.
- REQ: imem_req=1. When imem_ready=1, go to WAIT, clear counter. imem_req stays high and address stays stable until accepted.
- WAIT: imem_req=0. A response is legal no earlier than the cycle after acceptance.
  - imem_rvalid=1 with drop=0: instr<=imem_rdata, instr_valid<=1, go to DONE.
  - imem_rvalid=1 with drop=1: ignore data, clear drop, go to REQ (pc has already been redirected).
  - Counter increments each cycle without rvalid. When the counter reaches TIMEOUT, go to FAULT with code 10.
- DONE: instr_valid=1.
  - flush=1: instr_valid<=0, pc<=pc_next, go to REQ.
  - else stall=1: hold all state.
  - else: pc<=pc_next, instr_valid<=0, go to REQ.
- Flush in REQ: pc<=pc_next and stay in REQ. A request accepted in that same cycle uses the old address, so set drop=1 and go to WAIT.
- Flush in WAIT: pc<=pc_next, drop<=1. If rvalid arrives in the same cycle, discard it and go to REQ.
- Priority: reset > fault > flush > stall > normal advance. Stall is ignored outside DONE.
- Misalignment: any pc load with pc_next[1:0]!=0 goes to FAULT, code 01. pc still takes the bad value for debug.
- FAULT: absorbing until reset. imem_req=0, instr_valid=0, fault=1, fault_code held. A late rvalid is ignored.
- Throughput: with zero-wait memory, one instruction per 3 cycles (REQ, WAIT, DONE).
- Reset asserted mid-WAIT: all state clears immediately. A response arriving after reset release is ignored because state is IDLE/REQ and not WAIT.

Test Plan:
- Reset then imem_ready=1 always, rvalid one cycle after accept, pc_next=pc_plus4 -> imem_addr sequence 0x0,0x4,0x8; instr_valid pulses every 3rd cycle; instr matches rdata.
- DONE with stall=1 for 5 cycles -> instr and pc unchanged for 5 cycles, no imem_req; release -> pc=0x4 next cycle.
- Flush in WAIT with pc_next=0x100 and rvalid later with 0xDEADBEEF -> no instr_valid for that data; next imem_addr=0x100.
- pc_next=0x102 at advance -> fault=1, fault_code=01, imem_req=0 permanently until reset.
- Accept request, never assert rvalid -> after 255 WAIT cycles fault=1, fault_code=10.
- reset low during WAIT, then rvalid pulse after release -> pc=RESET_VECTOR, instr_valid stays 0, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: holds the architectural PC and runs the
// request/response handshake with instruction memory, handing fetched words to decode.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST   = 8'(TIMEOUT - 1);
  localparam logic       RV_MISALIGNED  = (RESET_VECTOR[1:0] != 2'b00);
  localparam logic [1:0] CODE_MISALIGN  = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT   = 2'b10;

  state_t     state;
  logic       drop;
  logic [7:0] count;
  logic       next_misaligned;

  assign pc_plus4        = pc + 32'd4;
  assign imem_addr       = pc;
  assign next_misaligned = (pc_next[1:0] != 2'b00);

  // drop marks a response already owed by memory for an address we redirected away from;
  // it is consumed by the next rvalid without reaching decode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= RESET_VECTOR;
      imem_req    <= 1'b0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      drop        <= 1'b0;
      count       <= 8'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (RV_MISALIGNED) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= CODE_MISALIGN;
          end else begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end

        S_REQ: begin
          if (flush) begin
            pc <= pc_next;
          end
          if (flush && next_misaligned) begin
            state      <= S_FAULT;
            imem_req   <= 1'b0;
            fault      <= 1'b1;
            fault_code <= CODE_MISALIGN;
          end else if (imem_ready) begin
            state    <= S_WAIT;
            imem_req <= 1'b0;
            drop     <= flush;
            count    <= 8'h0;
          end
        end

        S_WAIT: begin
          if (flush) begin
            pc <= pc_next;
          end
          if (flush && next_misaligned) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= CODE_MISALIGN;
          end else if (imem_rvalid) begin
            if (drop || flush) begin
              drop     <= 1'b0;
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= S_DONE;
            end
          end else begin
            drop  <= drop | flush;
            count <= count + 8'd1;
            if (count == TIMEOUT_LAST) begin
              state      <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= CODE_TIMEOUT;
            end
          end
        end

        // Stall only freezes a delivered instruction; a flush overrides it.
        S_DONE: begin
          if (flush || !stall) begin
            pc          <= pc_next;
            instr_valid <= 1'b0;
            if (next_misaligned) begin
              state      <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= CODE_MISALIGN;
            end else begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end
          end
        end

        S_FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fault       <= 1'b1;
        end

        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch sequence, stall, flush in WAIT/REQ, misalignment,
// timeout, reset mid-WAIT and pc_plus4 wrap, all with hand-computed expectations.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] pcNext;
  logic        stall;
  logic        flush;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] instr;
  logic        instrValid;
  logic        fault;
  logic [1:0]  faultCode;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clock      (clock),
    .reset      (reset),
    .pc_next    (pcNext),
    .stall      (stall),
    .flush      (flush),
    .imem_req   (imemReq),
    .imem_addr  (imemAddr),
    .imem_ready (imemReady),
    .imem_rvalid(imemRvalid),
    .imem_rdata (imemRdata),
    .pc         (pc),
    .pc_plus4   (pcPlus4),
    .instr      (instr),
    .instr_valid(instrValid),
    .fault      (fault),
    .fault_code (faultCode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] nextPc, input logic st, input logic fl,
                               input logic rdy, input logic rv, input logic [31:0] rdata);
    pcNext     = nextPc;
    stall      = st;
    flush      = fl;
    imemReady  = rdy;
    imemRvalid = rv;
    imemRdata  = rdata;
  endtask

  // Starting in REQ at addr, run one zero-wait fetch and leave the unit in DONE.
  task automatic fetchToDone(input string tag, input logic [31:0] addr, input logic [31:0] data);
    checkOutput({tag, " req"}, 32'(imemReq), 32'd1);
    checkOutput({tag, " addr"}, imemAddr, addr);
    applyStimulus(addr + 32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput({tag, " wait req"}, 32'(imemReq), 32'd0);
    checkOutput({tag, " wait valid"}, 32'(instrValid), 32'd0);
    applyStimulus(addr + 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, data);
    tick();
    applyStimulus(addr + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput({tag, " valid"}, 32'(instrValid), 32'd1);
    checkOutput({tag, " instr"}, instr, data);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset pc_plus4", pcPlus4, 32'h4);
    checkOutput("reset req", 32'(imemReq), 32'd0);
    checkOutput("reset valid", 32'(instrValid), 32'd0);
    checkOutput("reset instr", instr, 32'h0);
    checkOutput("reset fault", 32'(fault), 32'd0);
    checkOutput("reset code", 32'(faultCode), 32'd0);

    // Sequential fetches 0x0, 0x4, 0x8 at one instruction per three cycles.
    reset = 1'b1;
    tick();
    checkOutput("idle->req", 32'(imemReq), 32'd1);
    fetchToDone("f0", 32'h0, 32'h0000_0013);
    tick();
    checkOutput("adv0 pc", pc, 32'h4);
    checkOutput("adv0 valid", 32'(instrValid), 32'd0);
    fetchToDone("f4", 32'h4, 32'h0010_0093);
    tick();
    fetchToDone("f8", 32'h8, 32'h0020_8113);

    // Stall for five cycles in DONE.
    applyStimulus(32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall valid", 32'(instrValid), 32'd1);
      checkOutput("stall instr", instr, 32'h0020_8113);
      checkOutput("stall pc", pc, 32'h8);
      checkOutput("stall req", 32'(imemReq), 32'd0);
    end
    stall = 1'b0;
    tick();
    checkOutput("unstall pc", pc, 32'hC);
    checkOutput("unstall req", 32'(imemReq), 32'd1);

    // Flush during WAIT: the late response must not reach decode.
    applyStimulus(32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("wflush pc", pc, 32'h100);
    checkOutput("wflush req", 32'(imemReq), 32'd0);
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wflush drop valid", 32'(instrValid), 32'd0);
    checkOutput("wflush drop instr", instr, 32'h0020_8113);
    fetchToDone("f100", 32'h100, 32'hCAFE_0001);
    tick();

    // Flush in REQ while memory accepts: the accepted fetch is for the old address.
    applyStimulus(32'h200, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("rflush pc", pc, 32'h200);
    checkOutput("rflush req", 32'(imemReq), 32'd0);
    applyStimulus(32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
    tick();
    applyStimulus(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rflush drop valid", 32'(instrValid), 32'd0);
    fetchToDone("f200", 32'h200, 32'h2222_2222);

    // Misaligned advance: absorbing fault.
    pcNext = 32'h202;
    tick();
    checkOutput("mis fault", 32'(fault), 32'd1);
    checkOutput("mis code", 32'(faultCode), 32'd1);
    checkOutput("mis pc", pc, 32'h202);
    checkOutput("mis valid", 32'(instrValid), 32'd0);
    applyStimulus(32'h300, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("mis hold req", 32'(imemReq), 32'd0);
      checkOutput("mis hold valid", 32'(instrValid), 32'd0);
      checkOutput("mis hold code", 32'(faultCode), 32'd1);
    end

    // Timeout: accepted request never answered.
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("rst clears fault", 32'(fault), 32'd0);
    reset = 1'b1;
    tick();
    imemReady = 1'b1;
    tick();
    imemReady = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    checkOutput("to pre fault", 32'(fault), 32'd0);
    tick();
    checkOutput("to fault", 32'(fault), 32'd1);
    checkOutput("to code", 32'(faultCode), 32'd2);
    checkOutput("to req", 32'(imemReq), 32'd0);

    // Reset mid-WAIT, then a stray response after release.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    imemReady = 1'b1;
    tick();
    imemReady = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midrst pc", pc, 32'h0);
    checkOutput("midrst req", 32'(imemReq), 32'd0);
    checkOutput("midrst valid", 32'(instrValid), 32'd0);
    tick();
    reset = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_3333);
    tick();
    tick();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("stray valid", 32'(instrValid), 32'd0);
    checkOutput("stray instr", instr, 32'h0);
    fetchToDone("restart", 32'h0, 32'h4444_4444);
    tick();

    // Flush in REQ without acceptance, landing on the top word to check pc_plus4 wrap.
    applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    flush = 1'b0;
    checkOutput("wrap pc", pc, 32'hFFFF_FFFC);
    checkOutput("wrap addr", imemAddr, 32'hFFFF_FFFC);
    checkOutput("wrap plus4", pcPlus4, 32'h0);
    checkOutput("wrap req", 32'(imemReq), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
